sync_fifo_param: RTL and testbench

//   Single-clock, fully parametrised FIFO; next generation of the team's FIFO family.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_param.sv | 139 +++++++++++++
 tb/tb_sync_fifo_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing and pointer-wrap helpers for the parametrised FIFO family.
package fifo_pkg;

  function automatic int f_ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int f_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so any depth works, not only powers of two.
  function automatic logic [31:0] f_ptr_inc(input logic [31:0] ptr, input int depth);
    return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PW    = f_ptr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost flags, synchronous flush and selectable FWFT read stage.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0,
  parameter int CW        = f_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int            PW       = f_ptr_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             empty, full, wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // Handshake: wr_en_i/rd_en_i are requests sampled every edge; a request is
  // taken when its accept term is high, otherwise it raises a one-cycle
  // overflow/underflow pulse. A write into a full FIFO is taken only if a read
  // frees a slot on the same edge. flush_i suppresses both requests.
  always_comb begin
    rd_acc      = rd_en_i & ~empty & ~flush_i;
    wr_acc      = wr_en_i & (~full | rd_acc) & ~flush_i;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = PW'(f_ptr_inc(32'(wr_ptr_q), DEPTH));
      if (rd_acc) rd_ptr_d = PW'(f_ptr_inc(32'(rd_ptr_q), DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      overflow_d  = wr_en_i & ~wr_acc;
      underflow_d = rd_en_i & ~rd_acc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero while empty so stale memory never leaks.
      assign rvalid_o = ~empty;
      assign rdata_o  = empty ? '0 : mem_rdata;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q, rdata_d;
      logic             rvalid_q, rvalid_d;

      always_comb begin
        rdata_d  = rd_acc ? mem_rdata : rdata_q;
        rvalid_d = rd_acc;
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rdata_q  <= rdata_d;
          rvalid_q <= rvalid_d;
        end
      end

      assign rdata_o  = rdata_q;
      assign rvalid_o = rvalid_q;
    end
  endgenerate

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AFULL_C);
  assign almost_empty_o = (count_q <= AEMPTY_C);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three configurations share one directed stimulus
// stream and are each checked every cycle against a queue-based model.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, wr_en, rd_en;
  logic [15:0] wdata;

  logic [15:0] rdata0, rdata1, rdata2;
  logic        rvalid0, rvalid1, rvalid2;
  logic        full0, full1, full2, empty0, empty1, empty2;
  logic        af0, af1, af2, ae0, ae1, ae2;
  logic        ov0, ov1, ov2, un0, un1, un2;
  logic [4:0]  cnt0, cnt2;
  logic [2:0]  cnt1;

  sync_fifo_param #(.WIDTH(16), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(rdata0), .rvalid_o(rvalid0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(af0), .almost_empty_o(ae0), .count_o(cnt0), .overflow_o(ov0),
    .underflow_o(un0));

  sync_fifo_param #(.WIDTH(16), .DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(2), .FWFT(0)) u_d5 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(rdata1), .rvalid_o(rvalid1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1), .count_o(cnt1), .overflow_o(ov1),
    .underflow_o(un1));

  sync_fifo_param #(.WIDTH(16), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u_fw (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(rdata2), .rvalid_o(rvalid2), .full_o(full2), .empty_o(empty2),
    .almost_full_o(af2), .almost_empty_o(ae2), .count_o(cnt2), .overflow_o(ov2),
    .underflow_o(un2));

  localparam int DEP [3] = '{16, 5, 16};
  localparam int AFT [3] = '{14, 3, 14};
  localparam int AET [3] = '{2, 2, 2};
  localparam int FW  [3] = '{0, 0, 1};

  logic [15:0] exp_q [3][$];
  logic        m_ovf [3];
  logic        m_unf [3];
  logic        m_rv  [3];
  logic [15:0] m_rd  [3];
  bit          model_ok = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each FIFO is a plain queue; outputs follow from its length and history.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      bit rok, wok;
      if (!rst_n) begin
        exp_q[i].delete();
        m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_rv[i] = 1'b0; m_rd[i] = '0;
        model_ok = 1'b1;
      end else if (flush) begin
        exp_q[i].delete();
        m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_rv[i] = 1'b0;
      end else begin
        n   = exp_q[i].size();
        rok = rd_en && (n > 0);
        wok = wr_en && ((n < DEP[i]) || rok);
        m_ovf[i] = wr_en && !wok;
        m_unf[i] = rd_en && !rok;
        m_rv[i]  = rok;
        if (rok) m_rd[i] = exp_q[i].pop_front();
        if (wok) exp_q[i].push_back(wdata);
      end
    end
  end

  task automatic cmp(input int i, input logic [15:0] rd, input logic rv, input int cnt,
                     input logic e, input logic f, input logic af, input logic ae,
                     input logic ov, input logic un);
    int n;
    n = exp_q[i].size();
    check($sformatf("count[%0d]", i), cnt, n);
    check($sformatf("empty[%0d]", i), e, n == 0);
    check($sformatf("full[%0d]", i), f, n == DEP[i]);
    check($sformatf("almost_full[%0d]", i), af, n >= AFT[i]);
    check($sformatf("almost_empty[%0d]", i), ae, n <= AET[i]);
    check($sformatf("overflow[%0d]", i), ov, m_ovf[i]);
    check($sformatf("underflow[%0d]", i), un, m_unf[i]);
    if (FW[i] != 0) begin
      check($sformatf("rvalid[%0d]", i), rv, n > 0);
      if (n > 0) check($sformatf("rdata[%0d]", i), rd, exp_q[i][0]);
    end else begin
      check($sformatf("rvalid[%0d]", i), rv, m_rv[i]);
      check($sformatf("rdata[%0d]", i), rd, m_rd[i]);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      cmp(0, rdata0, rvalid0, int'(cnt0), empty0, full0, af0, ae0, ov0, un0);
      cmp(1, rdata1, rvalid1, int'(cnt1), empty1, full1, af1, ae1, ov1, un1);
      cmp(2, rdata2, rvalid2, int'(cnt2), empty2, full2, af2, ae2, ov2, un2);
    end
  end

  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic fl = 1'b0);
    wr_en = w; wdata = d; rd_en = r; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_count", cnt0, 0);
    check("rst_empty", empty0, 1);
    check("rst_full", full0, 0);
    check("rst_aempty", ae0, 1);
    check("rst_afull", af0, 0);
    check("rst_rdata", rdata0, 0);
    check("rst_rvalid", rvalid0, 0);
    check("rst_ovf", ov0, 0);
    check("rst_unf", un0, 0);
    check("rst_count_d5", cnt1, 0);
    check("rst_rdata_fw", rdata2, 0);
    check("rst_rvalid_fw", rvalid2, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    cyc(0, 16'h0, 0);
    cyc(0, 16'h0, 0);
    rst_n = 1'b1;
    check_reset_vals();

    // Fill 16 deep, then one write too many
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 16'(k), 0);
      check("fill_count", cnt0, k);
      check("fill_afull", af0, k >= 14);
    end
    check("fill_full", full0, 1);
    cyc(1, 16'h0011, 0);
    check("ovf_pulse", ov0, 1);
    check("ovf_count", cnt0, 16);
    cyc(0, 16'h0, 0);
    check("ovf_drop", ov0, 0);

    // Drain in order, then one read too many
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 16'h0, 1);
      check("drain_rdata", rdata0, k);
      check("drain_rvalid", rvalid0, 1);
    end
    check("drain_empty", empty0, 1);
    cyc(0, 16'h0, 1);
    check("unf_pulse", un0, 1);
    check("unf_rvalid", rvalid0, 0);
    cyc(0, 16'h0, 0);
    check("unf_drop", un0, 0);

    // Simultaneous read and write while full
    for (int k = 0; k < 16; k++) cyc(1, 16'(16'h0100 + k), 0);
    cyc(1, 16'hBEEF, 1);
    check("rw_full_count", cnt0, 16);
    check("rw_full_ovf", ov0, 0);
    check("rw_full_rdata", rdata0, 16'h0100);
    for (int k = 1; k <= 16; k++) cyc(0, 16'h0, 1);
    check("beef_last", rdata0, 16'hBEEF);

    // DEPTH=5 continuous traffic across pointer wrap
    cyc(0, 16'h0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 16'(16'h0200 + k), 0);
    check("d5_count", cnt1, 5);
    check("d5_full", full1, 1);
    for (int k = 5; k < 13; k++) begin
      cyc(1, 16'(16'h0200 + k), 1);
      check("d5_stream_count", cnt1, 5);
      check("d5_stream_rdata", rdata1, 16'(16'h0200 + k - 5));
    end
    for (int k = 8; k < 13; k++) begin
      cyc(0, 16'h0, 1);
      check("d5_tail_rdata", rdata1, 16'(16'h0200 + k));
    end
    check("d5_empty", empty1, 1);

    // FWFT visibility and pop
    cyc(0, 16'h0, 0, 1);
    cyc(1, 16'hA5A5, 0);
    check("fwft_rvalid", rvalid2, 1);
    check("fwft_rdata", rdata2, 16'hA5A5);
    cyc(0, 16'h0, 1);
    check("fwft_pop_empty", empty2, 1);
    check("fwft_pop_rvalid", rvalid2, 0);
    cyc(1, 16'h5A5A, 1);
    check("fwft_wr_rd_empty_unf", un2, 1);
    check("fwft_wr_rd_empty_cnt", cnt2, 1);
    check("fwft_wr_rd_empty_data", rdata2, 16'h5A5A);
    cyc(0, 16'h0, 1);

    // Flush with a concurrent write, then reset mid-burst
    cyc(0, 16'h0, 0, 1);
    for (int k = 0; k < 7; k++) cyc(1, 16'(16'h0300 + k), 0);
    check("pre_flush_count", cnt0, 7);
    cyc(1, 16'h0399, 0, 1);
    check("flush_count", cnt0, 0);
    check("flush_empty", empty0, 1);
    check("flush_ovf", ov0, 0);
    check("flush_fw_rvalid", rvalid2, 0);
    for (int k = 0; k < 4; k++) cyc(1, 16'(16'h0400 + k), 1);
    rst_n = 1'b0;
    cyc(1, 16'h0404, 1);
    check_reset_vals();
    rst_n = 1'b1;
    cyc(0, 16'h0, 0);
    cyc(0, 16'h0, 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
